// File: rtl/axis_pkt_arbiter_pkg.sv
// Shared types for the packet-locked AXI-Stream arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE waits for requests, BUSY holds a packet grant)
package axis_pkt_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/axis_skid.sv
// Two-entry AXI-Stream register slice with registered ready and registered outputs.
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_tvalid/s_tready/s_tdata  upstream handshake (s_tready registered, high while <= 1 entry held)
//   m_tvalid/m_tready/m_tdata  downstream handshake (held stable while stalled)
module axis_skid #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata
);

    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             main_valid_d;
    logic [WIDTH-1:0] main_data_d;
    logic             ready_d;
    logic             push, pop;

    assign push = s_tvalid & s_tready;
    assign pop  = m_tvalid & m_tready;

    // Next occupancy: the output register refills from the skid entry first, then from upstream.
    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        main_valid_d = m_tvalid;
        main_data_d  = m_tdata;
        if (!m_tvalid || pop) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = push;
                if (push) begin
                    main_data_d = s_tdata;
                end
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_tdata;
        end
        // The skid entry is only ever filled behind a full output register.
        ready_d = ~skid_valid_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            m_tvalid     <= 1'b0;
            m_tdata      <= '0;
            s_tready     <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            m_tvalid     <= main_valid_d;
            m_tdata      <= main_data_d;
            s_tready     <= ready_d;
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Round-robin, packet-locked arbiter merging INPUTS AXI-Stream sources into one sink.
// A grant is held from the first beat of a packet through its tlast beat.
// Ports:
//   aclk, aresetn                     clock, asynchronous active-low reset
//   s_tvalid_i/s_tready_o/s_tlast_i   per-source handshake, bit i = source i
//   s_tdata_i                         source i data at [i*WIDTH +: WIDTH]
//   m_tvalid_o/m_tready_i/m_tlast_o/m_tdata_o  merged stream (through a 2-entry slice)
//   grant_o                           one-hot current grant, 0 when idle
//   busy_o                            high while a packet is in progress
module axis_pkt_arbiter
    import axis_pkt_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned INPUTS = 2,
    parameter int unsigned GBITS  = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [INPUTS-1:0]       s_tvalid_i,
    output logic [INPUTS-1:0]       s_tready_o,
    input  logic [INPUTS-1:0]       s_tlast_i,
    input  logic [INPUTS*WIDTH-1:0] s_tdata_i,
    output logic                    m_tvalid_o,
    input  logic                    m_tready_i,
    output logic                    m_tlast_o,
    output logic [WIDTH-1:0]        m_tdata_o,
    output logic [INPUTS-1:0]       grant_o,
    output logic                    busy_o
);

    arb_state_e        state_q, state_d;
    logic [GBITS-1:0]  ptr_q, ptr_d;
    logic [GBITS-1:0]  gidx_q, gidx_d;
    logic [INPUTS-1:0] grant_q, grant_d;
    logic [GBITS-1:0]  pick;

    logic              sel_valid, sel_last;
    logic [WIDTH-1:0]  sel_data;
    logic              slice_valid, slice_ready, xfer;

    // First requesting index at or above ptr, searching cyclically.
    function automatic logic [GBITS-1:0] rr_pick(input logic [INPUTS-1:0] req,
                                                 input logic [GBITS-1:0]  ptr);
        logic [GBITS-1:0] res;
        logic [GBITS-1:0] cand;
        logic             found;
        res   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < INPUTS; k++) begin
            cand = GBITS'((32'(ptr) + k) % INPUTS);
            if (!found && req[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign pick = rr_pick(s_tvalid_i, ptr_q);

    // Only the granted source's signals reach the slice.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < INPUTS; i++) begin
            if (GBITS'(i) == gidx_q) begin
                sel_valid = s_tvalid_i[i];
                sel_last  = s_tlast_i[i];
                sel_data  = s_tdata_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign slice_valid = (state_q == BUSY) & sel_valid;
    assign xfer        = slice_valid & slice_ready;

    // Next-state: grant on the IDLE decision cycle, release on the tlast transfer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (|s_tvalid_i) begin
                    gidx_d  = pick;
                    grant_d = INPUTS'(1) << pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (xfer && sel_last) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (gidx_q == GBITS'(INPUTS - 1)) ? '0 : gidx_q + GBITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
        end
    end

    assign grant_o    = grant_q;
    assign busy_o     = (state_q == BUSY);
    assign s_tready_o = grant_q & {INPUTS{slice_ready}};

    axis_skid #(
        .WIDTH(WIDTH + 1)
    ) u_slice (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_tvalid(slice_valid),
        .s_tready(slice_ready),
        .s_tdata ({sel_last, sel_data}),
        .m_tvalid(m_tvalid_o),
        .m_tready(m_tready_i),
        .m_tdata ({m_tlast_o, m_tdata_o})
    );

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
module tb_axis_pkt_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic [N-1:0]   s_tvalid, s_tready, s_tlast;
    logic [N*W-1:0] s_tdata;
    logic           m_tvalid, m_tready, m_tlast;
    logic [W-1:0]   m_tdata;
    logic [N-1:0]   grant;
    logic           busy;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: packet-level arbitration plus a 2-deep output queue.
    bit         mb;
    int         mg;
    int         mptr;
    logic [W:0] mq[$];
    logic [W:0] srcq[N][$];
    bit         held[N];
    logic [W:0] dutlog[$];

    always #5 aclk = ~aclk;

    axis_pkt_arbiter #(.WIDTH(W), .INPUTS(N)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_tvalid_i(s_tvalid),
        .s_tready_o(s_tready),
        .s_tlast_i (s_tlast),
        .s_tdata_i (s_tdata),
        .m_tvalid_o(m_tvalid),
        .m_tready_i(m_tready),
        .m_tlast_o (m_tlast),
        .m_tdata_o (m_tdata),
        .grant_o   (grant),
        .busy_o    (busy)
    );

    function automatic logic [N-1:0] exp_grant();
        return mb ? (N'(1) << mg) : '0;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        return (mb && mq.size() < 2) ? exp_grant() : '0;
    endfunction

    function automatic bit pending();
        bit p;
        p = mb || (mq.size() > 0);
        for (int i = 0; i < N; i++) if (srcq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic add_pkt(input int src, input int len, input logic [W-1:0] base);
        for (int b = 0; b < len; b++) srcq[src].push_back({(b == len - 1), base + W'(b)});
    endtask

    // Drive sources (holding valid until accepted) and the sink ready; log DUT beats about to transfer.
    task automatic drive_inputs(input int pv, input int pr, input logic [N-1:0] stall);
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 && !stall[i] && (held[i] || int'($urandom_range(99)) < pv)) begin
                s_tvalid[i]           = 1'b1;
                held[i]               = 1'b1;
                s_tlast[i]            = srcq[i][0][W];
                s_tdata[i*W +: W]     = srcq[i][0][W-1:0];
            end else begin
                s_tvalid[i]           = 1'b0;
                held[i]               = 1'b0;
                s_tlast[i]            = 1'($urandom_range(1));
                s_tdata[i*W +: W]     = W'($urandom);
            end
        end
        m_tready = (int'($urandom_range(99)) < pr);
        if (m_tvalid && m_tready) dutlog.push_back({m_tlast, m_tdata});
    endtask

    // Advance the model across one rising edge using the inputs just applied.
    task automatic model_edge();
        int         sz;
        bit         pop, push;
        logic [W:0] beat;
        sz   = mq.size();
        pop  = (sz > 0) && m_tready;
        push = mb && s_tvalid[mg] && (sz < 2);
        if (pop) void'(mq.pop_front());
        if (push) begin
            beat = {s_tlast[mg], s_tdata[mg*W +: W]};
            mq.push_back(beat);
            void'(srcq[mg].pop_front());
            held[mg] = 1'b0;
            if (beat[W]) begin
                mb   = 1'b0;
                mptr = (mg + 1) % N;
            end
        end else if (!mb && s_tvalid != '0) begin
            for (int k = 0; k < N; k++) begin
                if (!mb && s_tvalid[(mptr + k) % N]) begin
                    mb = 1'b1;
                    mg = (mptr + k) % N;
                end
            end
        end
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b0;
        mb = 1'b0; mg = 0; mptr = 0;
        mq.delete();
        dutlog.delete();
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            held[i] = 1'b0;
        end
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        aresetn  = 1'b0;
        s_tvalid = '1;
        s_tlast  = '0;
        s_tdata  = '1;
        m_tready = 1'b1;
        #1;
        vectors++;
        if ({m_tvalid, m_tlast, m_tdata, s_tready, grant, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_values got v=%b l=%b d=%h rdy=%b g=%b busy=%b want all 0",
                     m_tvalid, m_tlast, m_tdata, s_tready, grant, busy);
        end
        do_reset();
        drive_inputs(100, 100, '0);
        @(posedge aclk); model_edge();
        @(negedge aclk);
        vectors++;
        if ({grant, busy, s_tready, m_tvalid} !== '0) begin
            miscompares++;
            $display("FAIL reset_idle got g=%b busy=%b rdy=%b v=%b want all 0", grant, busy, s_tready, m_tvalid);
        end
    endtask

    task automatic test_single_source();
        int c = 0;
        do_reset();
        add_pkt(0, 4, 8'h11);
        while (pending() && c < 200) begin
            drive_inputs(100, 100, '0);
            @(posedge aclk); model_edge();
            @(negedge aclk);
            vectors++;
            if ({grant, busy, s_tready, m_tvalid} !== {exp_grant(), mb, exp_ready(), mq.size() > 0}) begin
                miscompares++;
                $display("FAIL single_ctrl cyc=%0d got g=%b b=%b r=%b v=%b want g=%b b=%b r=%b v=%b",
                         c, grant, busy, s_tready, m_tvalid, exp_grant(), mb, exp_ready(), mq.size() > 0);
            end
            if (mq.size() > 0) begin
                vectors++;
                if ({m_tlast, m_tdata} !== mq[0]) begin
                    miscompares++;
                    $display("FAIL single_data cyc=%0d got %h want %h", c, {m_tlast, m_tdata}, mq[0]);
                end
            end
            c++;
        end
        vectors++;
        if (pending() || dutlog.size() != 4) begin
            miscompares++;
            $display("FAIL single_count got %0d beats want 4", dutlog.size());
        end else begin
            for (int b = 0; b < 4; b++) begin
                vectors++;
                if (dutlog[b] !== {(b == 3), 8'h11 + W'(b)}) begin
                    miscompares++;
                    $display("FAIL single_order beat %0d got %h want %h", b, dutlog[b], {(b == 3), 8'h11 + W'(b)});
                end
            end
        end
    endtask

    task automatic test_contention();
        int c = 0;
        logic [W-1:0] want;
        do_reset();
        add_pkt(0, 3, 8'hA1); add_pkt(0, 3, 8'hA1);
        add_pkt(1, 3, 8'hB1); add_pkt(1, 3, 8'hB1);
        while (pending() && c < 400) begin
            drive_inputs(100, 100, '0);
            @(posedge aclk); model_edge();
            @(negedge aclk);
            vectors++;
            if ({grant, busy, s_tready, m_tvalid} !== {exp_grant(), mb, exp_ready(), mq.size() > 0}) begin
                miscompares++;
                $display("FAIL contend_ctrl cyc=%0d got g=%b b=%b r=%b v=%b want g=%b b=%b r=%b v=%b",
                         c, grant, busy, s_tready, m_tvalid, exp_grant(), mb, exp_ready(), mq.size() > 0);
            end
            if (mq.size() > 0) begin
                vectors++;
                if ({m_tlast, m_tdata} !== mq[0]) begin
                    miscompares++;
                    $display("FAIL contend_data cyc=%0d got %h want %h", c, {m_tlast, m_tdata}, mq[0]);
                end
            end
            c++;
        end
        vectors++;
        if (pending() || dutlog.size() != 12) begin
            miscompares++;
            $display("FAIL contend_count got %0d beats want 12", dutlog.size());
        end else begin
            for (int b = 0; b < 12; b++) begin
                want = (((b / 3) % 2) == 0 ? 8'hA1 : 8'hB1) + W'(b % 3);
                vectors++;
                if (dutlog[b] !== {((b % 3) == 2), want}) begin
                    miscompares++;
                    $display("FAIL contend_order beat %0d got %h want %h", b, dutlog[b], {((b % 3) == 2), want});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int c = 0;
        do_reset();
        add_pkt(0, 8, 8'h40);
        while (pending() && c < 200) begin
            drive_inputs(100, (c >= 3 && c < 8) ? 0 : 100, '0);
            @(posedge aclk); model_edge();
            @(negedge aclk);
            vectors++;
            if ({grant, busy, s_tready, m_tvalid} !== {exp_grant(), mb, exp_ready(), mq.size() > 0}) begin
                miscompares++;
                $display("FAIL bp_ctrl cyc=%0d got g=%b b=%b r=%b v=%b want g=%b b=%b r=%b v=%b",
                         c, grant, busy, s_tready, m_tvalid, exp_grant(), mb, exp_ready(), mq.size() > 0);
            end
            if (mq.size() > 0) begin
                vectors++;
                if ({m_tlast, m_tdata} !== mq[0]) begin
                    miscompares++;
                    $display("FAIL bp_data cyc=%0d got %h want %h", c, {m_tlast, m_tdata}, mq[0]);
                end
            end
            if (c == 7) begin
                vectors++;
                if (s_tready !== '0 || m_tvalid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bp_full got rdy=%b v=%b want rdy=0000 v=1", s_tready, m_tvalid);
                end
            end
            c++;
        end
        vectors++;
        if (pending() || dutlog.size() != 8) begin
            miscompares++;
            $display("FAIL bp_count got %0d beats want 8", dutlog.size());
        end else begin
            for (int b = 0; b < 8; b++) begin
                vectors++;
                if (dutlog[b] !== {(b == 7), 8'h40 + W'(b)}) begin
                    miscompares++;
                    $display("FAIL bp_order beat %0d got %h want %h", b, dutlog[b], {(b == 7), 8'h40 + W'(b)});
                end
            end
        end
    endtask

    task automatic test_source_stall();
        int c = 0;
        do_reset();
        add_pkt(0, 6, 8'h60);
        add_pkt(1, 2, 8'h70);
        while (pending() && c < 200) begin
            drive_inputs(100, 100, (c >= 3 && c <= 5) ? N'(1) : '0);
            @(posedge aclk); model_edge();
            @(negedge aclk);
            vectors++;
            if ({grant, busy, s_tready, m_tvalid} !== {exp_grant(), mb, exp_ready(), mq.size() > 0}) begin
                miscompares++;
                $display("FAIL stall_ctrl cyc=%0d got g=%b b=%b r=%b v=%b want g=%b b=%b r=%b v=%b",
                         c, grant, busy, s_tready, m_tvalid, exp_grant(), mb, exp_ready(), mq.size() > 0);
            end
            if (mq.size() > 0) begin
                vectors++;
                if ({m_tlast, m_tdata} !== mq[0]) begin
                    miscompares++;
                    $display("FAIL stall_data cyc=%0d got %h want %h", c, {m_tlast, m_tdata}, mq[0]);
                end
            end
            if (c >= 3 && c <= 5) begin
                vectors++;
                if (grant !== 4'b0001 || s_tready[1] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_hold cyc=%0d got g=%b rdy=%b want g=0001 rdy[1]=0", c, grant, s_tready);
                end
            end
            c++;
        end
        vectors++;
        if (pending() || dutlog.size() != 8) begin
            miscompares++;
            $display("FAIL stall_count got %0d beats want 8", dutlog.size());
        end else begin
            for (int b = 0; b < 8; b++) begin
                vectors++;
                if (dutlog[b] !== ((b < 6) ? {(b == 5), 8'h60 + W'(b)} : {(b == 7), 8'h70 + W'(b - 6)})) begin
                    miscompares++;
                    $display("FAIL stall_order beat %0d got %h", b, dutlog[b]);
                end
            end
        end
    endtask

    task automatic test_single_beat();
        int c = 0;
        do_reset();
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) add_pkt(i, 1, W'(i));
        while (pending() && c < 200) begin
            drive_inputs(100, 100, '0);
            @(posedge aclk); model_edge();
            @(negedge aclk);
            vectors++;
            if ({grant, busy, s_tready, m_tvalid} !== {exp_grant(), mb, exp_ready(), mq.size() > 0}) begin
                miscompares++;
                $display("FAIL beat1_ctrl cyc=%0d got g=%b b=%b r=%b v=%b want g=%b b=%b r=%b v=%b",
                         c, grant, busy, s_tready, m_tvalid, exp_grant(), mb, exp_ready(), mq.size() > 0);
            end
            c++;
        end
        vectors++;
        if (pending() || dutlog.size() != 8) begin
            miscompares++;
            $display("FAIL beat1_count got %0d beats want 8", dutlog.size());
        end else begin
            for (int b = 0; b < 8; b++) begin
                vectors++;
                if (dutlog[b] !== {1'b1, W'(b % 4)}) begin
                    miscompares++;
                    $display("FAIL beat1_order beat %0d got %h want %h", b, dutlog[b], {1'b1, W'(b % 4)});
                end
            end
        end
    endtask

    task automatic test_random();
        int c = 0;
        int total = 0;
        int len;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < N; i++) begin
                len = int'($urandom_range(5, 1));
                add_pkt(i, len, W'($urandom));
                total += len;
            end
        end
        while (pending() && c < 3000) begin
            drive_inputs(70, 60, '0);
            @(posedge aclk); model_edge();
            @(negedge aclk);
            vectors++;
            if ({grant, busy, s_tready, m_tvalid} !== {exp_grant(), mb, exp_ready(), mq.size() > 0}) begin
                miscompares++;
                $display("FAIL rand_ctrl cyc=%0d got g=%b b=%b r=%b v=%b want g=%b b=%b r=%b v=%b",
                         c, grant, busy, s_tready, m_tvalid, exp_grant(), mb, exp_ready(), mq.size() > 0);
            end
            if (mq.size() > 0) begin
                vectors++;
                if ({m_tlast, m_tdata} !== mq[0]) begin
                    miscompares++;
                    $display("FAIL rand_data cyc=%0d got %h want %h", c, {m_tlast, m_tdata}, mq[0]);
                end
            end
            c++;
        end
        vectors++;
        if (pending() || dutlog.size() != total) begin
            miscompares++;
            $display("FAIL rand_count got %0d beats want %0d", dutlog.size(), total);
        end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        do_reset();
        add_pkt(0, 1, 8'h20);
        add_pkt(1, 4, 8'h31);
        while (srcq[1].size() > 2 && c < 100) begin
            drive_inputs(100, 100, '0);
            @(posedge aclk); model_edge();
            @(negedge aclk);
            c++;
        end
        vectors++;
        if (srcq[1].size() != 2 || grant !== 4'b0010) begin
            miscompares++;
            $display("FAIL rstmid_setup got left=%0d g=%b want left=2 g=0010", srcq[1].size(), grant);
        end
        aresetn = 1'b0;
        #1;
        vectors++;
        if ({m_tvalid, m_tlast, m_tdata, s_tready, grant, busy} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_clear got v=%b l=%b d=%h rdy=%b g=%b busy=%b want all 0",
                     m_tvalid, m_tlast, m_tdata, s_tready, grant, busy);
        end
        do_reset();
        add_pkt(1, 2, 8'h61);
        add_pkt(0, 2, 8'h51);
        c = 0;
        while (pending() && c < 200) begin
            drive_inputs(100, 100, '0);
            @(posedge aclk); model_edge();
            @(negedge aclk);
            if (c == 0) begin
                vectors++;
                if (grant !== 4'b0001) begin
                    miscompares++;
                    $display("FAIL rstmid_ptr got g=%b want 0001", grant);
                end
            end
            vectors++;
            if ({grant, busy, s_tready, m_tvalid} !== {exp_grant(), mb, exp_ready(), mq.size() > 0}) begin
                miscompares++;
                $display("FAIL rstmid_ctrl cyc=%0d got g=%b b=%b r=%b v=%b want g=%b b=%b r=%b v=%b",
                         c, grant, busy, s_tready, m_tvalid, exp_grant(), mb, exp_ready(), mq.size() > 0);
            end
            c++;
        end
        vectors++;
        if (pending() || dutlog.size() != 4) begin
            miscompares++;
            $display("FAIL rstmid_count got %0d beats want 4", dutlog.size());
        end else begin
            for (int b = 0; b < 4; b++) begin
                vectors++;
                if (dutlog[b] !== ((b < 2) ? {(b == 1), 8'h51 + W'(b)} : {(b == 3), 8'h61 + W'(b - 2)})) begin
                    miscompares++;
                    $display("FAIL rstmid_order beat %0d got %h", b, dutlog[b]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_contention();
        test_backpressure();
        test_source_stall();
        test_single_beat();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t want test completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
